// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU MEM stage (m0)
// and a debug/DMA loader (m1). Grants are round-robin per access, and the block
// owns a sequential clear engine that zeroes every DM word, one word per cycle.
// Optional trace output is enabled by defining DM_ARB_TRACE_EN. It prints granted
// writes and the end of each clear sweep. Without the macro no messages are printed.
module dm_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          rr_last_q, rr_last_d;   // last master served (0 = m0, 1 = m1)
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_done_q, clr_done_d;

  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

  // Read data is shared; each requester qualifies it with its own grant.
  assign m0_rdata = dm_rdata;
  assign m1_rdata = dm_rdata;
  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = clr_done_q;

  // State registers; rr_last starts at 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      rr_last_q  <= 1'b1;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Grant decision, DM port mux and clear-sweep sequencing.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie, serve the master that was not served last.
        if (m0_req && (!m1_req || rr_last_q)) begin
          m0_gnt = 1'b1;
        end else if (m1_req) begin
          m1_gnt = 1'b1;
        end

        if (m0_gnt) begin
          dm_addr   = m0_addr;
          dm_wdata  = m0_wdata;
          dm_we     = m0_we;
          rr_last_d = 1'b0;
        end else if (m1_gnt) begin
          dm_addr   = m1_addr;
          dm_wdata  = m1_wdata;
          dm_we     = m1_we;
          rr_last_d = 1'b1;
        end

        // A coinciding request is still served; the sweep begins next cycle.
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end

      S_CLEAR: begin
        // Requests stall while the sweep owns the port. clr_start is ignored here.
        dm_we     = 1'b1;
        dm_wdata  = '0;
        dm_addr   = {{(30 - AW){1'b0}}, clr_cnt_q, 2'b00};
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d    = S_IDLE;
          clr_cnt_d  = '0;
          clr_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef DM_ARB_TRACE_EN
  // Trace granted writes and sweep completion.
  always_ff @(posedge clk) begin
    if (Reset) begin
      if (m0_gnt && m0_we) begin
        $display("%d@m%0d: *%h <= %h", $time, 0, m0_addr, m0_wdata);
      end
      if (m1_gnt && m1_we) begin
        $display("%d@m%0d: *%h <= %h", $time, 1, m1_addr, m1_wdata);
      end
      if (clr_done_q) begin
        $display("%d: dm clear done", $time);
      end
    end
  end
`endif

endmodule
